iiitb_sd_sched: RTL and testbench
=================================

Name: iiitb_sd_sched

Overview:
- Round-robin scheduler that shares one Moore sequence-detector core among N_REQ serial-bitstream requesters.
- Grants one requester at a time for a fixed frame of FRAME_LEN bits.
- Clears the detector before each frame, steers the granted stream onto the detector's data input, counts detector matches over the frame, and reports the count with the requester id.
- Sits between the requester channels and the detector instance.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- FRAME_LEN, 8, bits streamed per grant (>=1)
- CNT_W, 4, width of match counter (saturating)
- ID_W, 2, width of requester id, equals clog2(N_REQ)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester frame request, level
- req_din  in  N_REQ  per-requester serial data bit
- grant  out  N_REQ  one-hot grant, held CLR through DRAIN
- shift  out  1  granted requester's req_din is consumed this cycle; requester advances its bit
- sd_clr  out  1  synchronous active-high clear to detector, one-cycle pulse
- sd_din  out  1  data to detector
- sd_y  in  1  detector Moore output
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, frame result valid
- done_id  out  ID_W  requester id of completed frame, held until next done
- match_cnt  out  CNT_W  matches in completed frame, held until next done

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; grant, shift, sd_clr, sd_din, busy, done, done_id, match_cnt all 0.
  - Round-robin pointer = N_REQ-1, so req[0] wins first.
- FSM states: IDLE, CLR, STREAM, DRAIN, REPORT. All outputs are registered except sd_din and shift, which decode from state/grant.
- IDLE:
  - If req!=0, select the first asserted requester searching from pointer+1 with wrap. Load grant one-hot and go to CLR.
  - Otherwise stay in IDLE.
  - req is sampled only in IDLE; deasserting req mid-frame does not abort the frame.
- CLR (1 cycle): sd_clr=1, sd_din=0, shift=0. Clear the bit counter and match counter. Next state is STREAM.
- STREAM (FRAME_LEN cycles):
  - shift=1; sd_din = req_din of the granted requester (combinational mux).
  - Bit counter increments each cycle; after the FRAME_LEN-th bit, go to DRAIN.
- DRAIN (1 cycle): shift=0, sd_din=0, grant held. Covers the 1-cycle detector Moore latency. Next state is REPORT.
- Match counting:
  - Define y_valid = shift delayed one cycle.
  - In any cycle with y_valid=1 and sd_y=1, match counter +1, saturating at 2^CNT_W-1.
  - sd_y is ignored when y_valid=0, including the CLR cycle and the first STREAM cycle.
- REPORT (1 cycle):
  - done=1; done_id = granted index; match_cnt = counter.
  - grant cleared; pointer = granted index. Next state is IDLE.
- Timing: req sampled in IDLE at cycle t gives:
  - grant at t+1
  - shift at t+2 .. t+1+FRAME_LEN
  - done at t+3+FRAME_LEN
  - next possible grant at t+5+FRAME_LEN (IDLE at t+4+FRAME_LEN)
- Fairness: with all requesters continuously asserting, grants rotate 0,1,...,N_REQ-1,0. A requester waits at most N_REQ-1 frames.
- Asynchronous reset mid-frame: everything returns to reset values immediately. Held done_id and match_cnt are lost. No done is produced for the aborted frame.
- grant is always one-hot or zero. done never coincides with grant!=0.

Test Plan:
- Single request: req=0001, req_din[0]=1,1,1,0,1,0,1,0, bench drives sd_y=1 on the 3rd, 5th and 7th y_valid cycles. Expect grant=0001 at t+1, sd_clr pulse at t+1, shift for 8 cycles, done at t+11 with done_id=0 and match_cnt=3.
- Round-robin: req=1111 held for 5 frames. Expect done_id sequence 0,1,2,3,0, with done pulses 12 cycles apart and grant always one-hot.
- Saturation: FRAME_LEN=20, CNT_W=4, sd_y held 1. Expect match_cnt=15, not a wrapped value.
- Window masking: sd_y=1 only during the CLR cycle and the first STREAM cycle, 0 otherwise. Expect match_cnt=0.
- Request drop and pointer: req=0110; drop req[1] two cycles into STREAM. Expect the frame to complete with done_id=1, then the next grant=0100.
- Reset mid-STREAM: assert reset=0 at bit 4. Expect grant, shift, busy and sd_clr to be 0 immediately and no done. After release with req=0001, expect the first grant to requester 0.

Source files
------------

// File: rtl/iiitb_sd_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// iiitb_sd_sched
// Round-robin scheduler that time-shares one Moore sequence-detector core
// among N_REQ serial-bitstream requesters. Each grant is one frame:
// CLR (detector cleared) -> STREAM (FRAME_LEN bits) -> DRAIN (covers the
// detector's one-cycle Moore latency) -> REPORT (done pulse with result).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   req        per-requester frame request (level, sampled only in IDLE)
//   req_din    per-requester serial data bit
//   grant      one-hot grant, held from CLR through DRAIN
//   shift      granted requester's bit is consumed this cycle
//   sd_clr     one-cycle synchronous clear pulse to the detector
//   sd_din     data bit to the detector
//   sd_y       detector Moore output
//   busy       high in every state except IDLE
//   done       one-cycle pulse, frame result valid
//   done_id    requester id of the completed frame (held until next done)
//   match_cnt  saturating match count of the completed frame (held)
//   dbg_state  current FSM state encoding, for observation only
//
// Handshake: a requester raises req and keeps it high until it sees its grant
// bit; while grant is its own and shift=1, the value on its req_din lane is
// consumed at the end of that cycle and the requester presents the next bit.
// -----------------------------------------------------------------------------
module iiitb_sd_sched #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4,
    parameter int ID_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_din,
    output logic [N_REQ-1:0] grant,
    output logic             shift,
    output logic             sd_clr,
    output logic             sd_din,
    input  logic             sd_y,
    output logic             busy,
    output logic             done,
    output logic [ID_W-1:0]  done_id,
    output logic [CNT_W-1:0] match_cnt,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam int                 BIT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [N_REQ-1:0]   GNT_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_next;
    logic [N_REQ-1:0]   r_grant;
    logic [ID_W-1:0]    r_gnt_idx;
    logic [ID_W-1:0]    r_ptr;
    logic [BIT_W-1:0]   r_bit;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_y_valid;
    logic               r_sd_clr;
    logic               r_busy;
    logic               r_done;
    logic [ID_W-1:0]    r_done_id;
    logic [CNT_W-1:0]   r_match_cnt;
    logic               w_shift;
    logic               w_sel_found;
    logic [ID_W-1:0]    w_sel_idx;
    logic [ID_W-1:0]    w_cand;

    // Round-robin pick: first asserted req searching from r_ptr+1 with wrap,
    // so the last-served requester is considered last.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_sel_found && req[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_sel_found) w_state_next = S_CLR;
            S_CLR:    w_state_next = S_STREAM;
            S_STREAM: if (r_bit == LAST_BIT) w_state_next = S_DRAIN;
            S_DRAIN:  w_state_next = S_REPORT;
            S_REPORT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // r_y_valid marks cycles where sd_y reflects a streamed bit (detector
    // output lags its input by one cycle); everything else is ignored.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_y_valid && sd_y && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant     <= '0;
            r_gnt_idx   <= '0;
            r_ptr       <= ID_W'(N_REQ - 1);
            r_bit       <= '0;
            r_cnt       <= '0;
            r_y_valid   <= 1'b0;
            r_sd_clr    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= '0;
            r_match_cnt <= '0;
        end else begin
            r_y_valid <= w_shift;
            r_sd_clr  <= (w_state_next == S_CLR);
            r_busy    <= (w_state_next != S_IDLE);
            r_done    <= (w_state_next == S_REPORT);
            case (r_state)
                S_IDLE: begin
                    if (w_sel_found) begin
                        r_grant   <= GNT_ONE << w_sel_idx;
                        r_gnt_idx <= w_sel_idx;
                    end
                end
                S_CLR: begin
                    r_bit <= '0;
                    r_cnt <= '0;
                end
                S_STREAM: begin
                    r_bit <= r_bit + BIT_W'(1);
                    r_cnt <= w_cnt_next;
                end
                S_DRAIN: begin
                    // Last streamed bit's detector response arrives here, so the
                    // result latched for REPORT includes this cycle's sd_y.
                    r_cnt       <= w_cnt_next;
                    r_match_cnt <= w_cnt_next;
                    r_done_id   <= r_gnt_idx;
                    r_grant     <= '0;
                end
                S_REPORT: begin
                    r_ptr <= r_gnt_idx;
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign w_shift   = (r_state == S_STREAM);
    assign shift     = w_shift;
    assign sd_din    = w_shift & req_din[r_gnt_idx];
    assign grant     = r_grant;
    assign sd_clr    = r_sd_clr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign match_cnt = r_match_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_iiitb_sd_sched.sv
`timescale 1ns/1ps
module tb_iiitb_sd_sched;

    localparam int N      = 4;
    localparam int FL     = 8;
    localparam int CW     = 4;
    localparam int IW     = 2;
    localparam int FL_SAT = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // main instance
    logic [N-1:0]  req, req_din;
    logic          sd_y;
    logic [N-1:0]  grant;
    logic          shift, sd_clr, sd_din, busy, done;
    logic [IW-1:0] done_id;
    logic [CW-1:0] match_cnt;
    logic [2:0]    dbg_state;

    // long-frame instance for saturation
    logic [N-1:0]  s_req, s_req_din;
    logic          s_sd_y;
    logic [N-1:0]  s_grant;
    logic          s_shift, s_sd_clr, s_sd_din, s_busy, s_done;
    logic [IW-1:0] s_done_id;
    logic [CW-1:0] s_match_cnt;
    logic [2:0]    s_dbg_state;

    iiitb_sd_sched #(.N_REQ(N), .FRAME_LEN(FL), .CNT_W(CW), .ID_W(IW)) u_dut (
        .clk(clk), .reset(reset), .req(req), .req_din(req_din),
        .grant(grant), .shift(shift), .sd_clr(sd_clr), .sd_din(sd_din),
        .sd_y(sd_y), .busy(busy), .done(done), .done_id(done_id),
        .match_cnt(match_cnt), .dbg_state(dbg_state)
    );

    iiitb_sd_sched #(.N_REQ(N), .FRAME_LEN(FL_SAT), .CNT_W(CW), .ID_W(IW)) u_dut_sat (
        .clk(clk), .reset(reset), .req(s_req), .req_din(s_req_din),
        .grant(s_grant), .shift(s_shift), .sd_clr(s_sd_clr), .sd_din(s_sd_din),
        .sd_y(s_sd_y), .busy(s_busy), .done(s_done), .done_id(s_done_id),
        .match_cnt(s_match_cnt), .dbg_state(s_dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [IW+CW-1:0] exp_q[$];
    logic             exp_bit_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               m_ptr;
    logic [IW+CW-1:0] mon_e;

    function automatic void chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp_v, $time);
        end
    endfunction

    // Reference: arbitration is "next asserted requester after the last one served".
    function automatic int rr_pick(input logic [N-1:0] rq, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (rq[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Reference: matches = number of 1s the detector reported for the frame's bits, saturated.
    function automatic int sat_cnt(input logic [31:0] p, input int fl);
        int n;
        n = 0;
        for (int i = 0; i < fl; i++) n += int'(p[i]);
        return (n > (2**CW - 1)) ? (2**CW - 1) : n;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            chk("grant_onehot0", int'((grant & (grant - 1'b1)) == '0), 1);
            if (done) begin
                chk("done_grant_zero", int'(grant), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_id", int'(done_id), int'(mon_e[IW+CW-1:CW]));
                    chk("match_cnt", int'(match_cnt), int'(mon_e[CW-1:0]));
                end
            end
            if (shift) begin
                if (exp_bit_q.size() == 0) chk("unexpected_shift", 1, 0);
                else chk("sd_din", int'(sd_din), int'(exp_bit_q.pop_front()));
            end else begin
                chk("sd_din_quiet", int'(sd_din), 0);
            end
        end
    end

    // ---------------- driver ----------------
    // Cycle c=0 is the IDLE cycle in which req is presented; the frame then
    // occupies c=1 (CLR) .. c=FL+3 (REPORT).
    task automatic run_frame(input logic [N-1:0] rq, input logic [N-1:0] drop_mask,
                             input logic [31:0] ypat, input int ymode,
                             input logic [31:0] din_pat, input bit use_din,
                             input int abort_at);
        int w;
        logic [N-1:0] cur, one_v, gexp;
        w     = rr_pick(rq, m_ptr);
        one_v = 1;
        gexp  = one_v << w;
        cur   = rq;
        if (abort_at < 0) exp_q.push_back({IW'(w), CW'(sat_cnt(ypat, FL))});
        for (int c = 0; c <= FL + 3; c++) begin
            @(posedge clk);
            #1;
            if (c == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_grant", int'(grant), 0);
                chk("abort_shift", int'(shift), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_sd_clr", int'(sd_clr), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_done_id", int'(done_id), 0);
                chk("abort_match_cnt", int'(match_cnt), 0);
                m_ptr = N - 1;
                return;
            end
            if (c == 4) cur = rq & ~drop_mask;
            req     = cur;
            req_din = N'($urandom);
            if (use_din && c >= 2 && c <= FL + 1) req_din[w] = din_pat[c-2];
            if (c >= 3 && c <= FL + 2) sd_y = ypat[c-3];
            else if (ymode == 1)       sd_y = (c == 1 || c == 2);
            else                       sd_y = 1'($urandom_range(0, 1));
            if (c >= 2 && c <= FL + 1) exp_bit_q.push_back(req_din[w]);
            @(negedge clk);
            if (c == 0) begin
                chk("idle_busy", int'(busy), 0);
                chk("idle_grant", int'(grant), 0);
            end else if (c == 1) begin
                chk("clr_grant", int'(grant), int'(gexp));
                chk("clr_sd_clr", int'(sd_clr), 1);
                chk("clr_busy", int'(busy), 1);
                chk("clr_shift", int'(shift), 0);
            end else if (c <= FL + 1) begin
                chk("stream_shift", int'(shift), 1);
                chk("stream_grant", int'(grant), int'(gexp));
                chk("stream_sd_clr", int'(sd_clr), 0);
            end else if (c == FL + 2) begin
                chk("drain_shift", int'(shift), 0);
                chk("drain_grant", int'(grant), int'(gexp));
                chk("drain_done", int'(done), 0);
            end else begin
                chk("report_done", int'(done), 1);
                chk("report_busy", int'(busy), 1);
            end
        end
        m_ptr = w;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int got;
        logic [N-1:0] rq;
        reset = 1'b0; req = '0; req_din = '0; sd_y = 1'b0;
        s_req = '0; s_req_din = '0; s_sd_y = 1'b0;
        m_ptr = N - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_shift", int'(shift), 0);
        chk("rst_sd_clr", int'(sd_clr), 0);
        chk("rst_sd_din", int'(sd_din), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_id", int'(done_id), 0);
        chk("rst_match_cnt", int'(match_cnt), 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // round-robin with all requesting: ids 0,1,2,3,0
        for (int f = 0; f < 5; f++) run_frame(4'b1111, '0, $urandom, 0, '0, 1'b0, -1);
        // single request with the fixed bit/detector pattern: 3 matches
        run_frame(4'b0001, '0, 32'h54, 0, 32'h57, 1'b1, -1);
        // detector activity only outside the counting window
        run_frame(4'b0001, '0, 32'h0, 1, '0, 1'b0, -1);
        // request drop mid-frame, then pointer moves past requester 1
        run_frame(4'b0110, 4'b0010, $urandom, 0, '0, 1'b0, -1);
        run_frame(4'b0100, '0, $urandom, 0, '0, 1'b0, -1);
        // random traffic
        for (int f = 0; f < 8; f++) begin
            rq = N'($urandom_range(1, 2**N - 1));
            run_frame(rq, '0, $urandom, 0, '0, 1'b0, -1);
        end
        run_frame(4'b1111, '0, 32'hFF, 0, '0, 1'b0, -1);
        // reset during bit 4 of STREAM
        run_frame(4'b0011, '0, $urandom, 0, '0, 1'b0, 6);
        req = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (FL + 4) @(posedge clk);
        run_frame(4'b1111, '0, $urandom, 0, '0, 1'b0, -1);
        run_frame(4'b0001, '0, $urandom, 0, '0, 1'b0, -1);
        @(posedge clk); #1 req = '0;
        repeat (FL + 4) @(posedge clk);

        // saturation on the long-frame instance: 20 matches -> 15
        @(posedge clk); #1;
        s_req = 4'b0001; s_sd_y = 1'b1; s_req_din = N'($urandom);
        got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            @(negedge clk);
            if (s_done) begin
                got = 1;
                chk("sat_done_id", int'(s_done_id), 0);
                chk("sat_match_cnt", int'(s_match_cnt), 2**CW - 1);
            end
        end
        if (got == 0) chk("sat_done_timeout", 0, 1);
        s_req = '0;

        chk("exp_q_empty", exp_q.size(), 0);
        chk("exp_bit_q_empty", exp_bit_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
